// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//
// Shared definitions for both sides of the asynchronous FIFO.
//
// Contents:
//   FIFO_ADDR_WIDTH : default memory address width (depth = 2**FIFO_ADDR_WIDTH)
//   GRAY_MAX_W      : widest pointer the conversion helpers handle
//   gray_word_t     : container type for the conversion helpers
//   bin2gray()      : binary -> Gray. Zero-extended inputs convert correctly,
//                     so one function serves every pointer width.
//   gray2bin()      : Gray -> binary over the low 'width' bits. Bits above
//                     'width' are ignored and return as zero.
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int GRAY_MAX_W      = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    function automatic gray_word_t bin2gray(input gray_word_t bin_val);
        return bin_val ^ (bin_val >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it, counting
    // only the low 'width' bits.
    function automatic gray_word_t gray2bin(input gray_word_t gray_val,
                                            input int         width);
        gray_word_t bin_val;
        logic       acc;
        bin_val = '0;
        acc     = 1'b0;
        for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
            if (i < width) begin
                acc        = acc ^ gray_val[i];
                bin_val[i] = acc;
            end
        end
        return bin_val;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// ---------------------------------------------------------------------------
// gray2bin
//
// Purely combinational Gray-to-binary converter. The write side uses it on
// the synchronized read pointer. The read side uses it on the synchronized
// write pointer.
//
// Parameters:
//   WIDTH : pointer width in bits
//
// Ports:
//   gray  in   WIDTH  Gray-coded value
//   bin   out  WIDTH  binary equivalent
// ---------------------------------------------------------------------------
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each bin bit is a reduction XOR of the Gray bits from the MSB down to
    // that bit. This form avoids a ripple chain through 'bin' itself, so
    // there is no apparent combinational loop.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign bin[gi] = ^gray[WIDTH-1:gi];
        end
    endgenerate

endmodule

// File: rtl/fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_wr_ctrl
//
// Write-side pointer and flag controller of the asynchronous FIFO. All logic
// is in the write-clock domain. The block does the following:
//   - accepts write requests and drives the memory write port;
//   - keeps a binary write pointer and publishes its Gray-coded copy;
//   - derives full, almost-full and sticky overflow from the read pointer.
//     That read pointer is already synchronized into this domain outside the
//     block, and this block adds no synchronizer stages.
//
// Optional build macro:
//   FIFO_WR_CTRL_AFULL_EN
//     defined     : the almost-full compare and the wafull register are built.
//     not defined : wafull is tied to 0 and AFULL_THRESH is ignored.
//                   The port list is the same in both builds.
//
// Parameters:
//   ADDR_WIDTH   : memory address width. Pointers are ADDR_WIDTH+1 bits.
//   AFULL_THRESH : occupancy at or above which wafull asserts
//                  (legal range 1..2**ADDR_WIDTH).
//
// Ports:
//   w_clk       in   1             write-domain clock (rising edge)
//   w_rst       in   1             asynchronous active-low reset
//   winc        in   1             write request
//   r_ptr       in   ADDR_WIDTH+1  Gray read pointer, already synchronized
//   wfull       out  1             registered full flag
//   wafull      out  1             registered almost-full flag
//   w_overflow  out  1             sticky: a write was attempted while full
//   wen         out  1             memory write enable (combinational)
//   waddr       out  ADDR_WIDTH    memory write address
//   w_ptr       out  ADDR_WIDTH+1  registered Gray write pointer
//   w_count     out  ADDR_WIDTH+1  occupancy as seen by the write side
// ---------------------------------------------------------------------------
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = FIFO_ADDR_WIDTH,
    parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 2
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   r_ptr,
    output logic                  wfull,
    output logic                  wafull,
    output logic                  w_overflow,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   w_ptr,
    output logic [ADDR_WIDTH:0]   w_count
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    // -----------------------------------------------------------------------
    // State and next-state signals
    // -----------------------------------------------------------------------
    logic [PTR_W-1:0] w_bin_reg;
    logic [PTR_W-1:0] w_bin_next;
    logic [PTR_W-1:0] w_gray_reg;
    logic [PTR_W-1:0] w_gray_next;
    logic             wfull_reg;
    logic             wfull_next;
    logic             overflow_reg;
    logic             overflow_next;

    logic [PTR_W-1:0] r_bin;
    logic [PTR_W-1:0] full_gray;

    // -----------------------------------------------------------------------
    // Read pointer in binary, for the occupancy and almost-full compares
    // -----------------------------------------------------------------------
    gray2bin #(
        .WIDTH (PTR_W)
    ) u_rptr_g2b (
        .gray (r_ptr),
        .bin  (r_bin)
    );

    // -----------------------------------------------------------------------
    // Write acceptance and next-pointer computation
    // -----------------------------------------------------------------------
    // wfull is the registered flag. A request arriving in the cycle where the
    // read pointer first moves off a full FIFO is therefore still dropped.
    // This keeps the flag conservative.
    assign wen = winc & ~wfull_reg;

    assign w_bin_next  = w_bin_reg + PTR_W'(wen);
    assign w_gray_next = PTR_W'(bin2gray(gray_word_t'(w_bin_next)));

    // Full means the write pointer is exactly one lap ahead of the read
    // pointer. In Gray code, that lap differs from the read pointer in the
    // top two bits and matches it in all the others.
    assign full_gray  = {~r_ptr[PTR_W-1:PTR_W-2], r_ptr[PTR_W-3:0]};
    assign wfull_next = (w_gray_next == full_gray);

    assign overflow_next = overflow_reg | (winc & wfull_reg);

    // -----------------------------------------------------------------------
    // Register group: pointers
    // -----------------------------------------------------------------------
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            w_bin_reg  <= '0;
            w_gray_reg <= '0;
        end else begin
            w_bin_reg  <= w_bin_next;
            w_gray_reg <= w_gray_next;
        end
    end

    // -----------------------------------------------------------------------
    // Register group: full flag
    // -----------------------------------------------------------------------
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            wfull_reg <= 1'b0;
        end else begin
            wfull_reg <= wfull_next;
        end
    end

    // -----------------------------------------------------------------------
    // Register group: sticky overflow
    // -----------------------------------------------------------------------
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= overflow_next;
        end
    end

    // -----------------------------------------------------------------------
    // Register group: almost-full (optional)
    // -----------------------------------------------------------------------
`ifdef FIFO_WR_CTRL_AFULL_EN
    localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_THRESH);

    logic [PTR_W-1:0] occ_next;
    logic             wafull_next;
    logic             wafull_reg;

    // Use the post-write occupancy, so the flag reflects a write on the same
    // edge that accepts it. The subtraction wraps modulo 2**PTR_W. That
    // wrap is correct because the occupancy never exceeds the depth.
    assign occ_next    = w_bin_next - r_bin;
    assign wafull_next = (occ_next >= AFULL_LVL);

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            wafull_reg <= 1'b0;
        end else begin
            wafull_reg <= wafull_next;
        end
    end

    assign wafull = wafull_reg;
`else
    assign wafull = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign wfull      = wfull_reg;
    assign w_overflow = overflow_reg;
    assign waddr      = w_bin_reg[ADDR_WIDTH-1:0];
    assign w_ptr      = w_gray_reg;
    assign w_count    = w_bin_reg - r_bin;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_ctrl
//
// Directed bench for fifo_wr_ctrl with ADDR_WIDTH=4 and AFULL_THRESH=14.
// Expected values come from hand-picked constants and from a small
// occupancy model:
//   full       when writes minus reads equals 16;
//   almost-full when writes minus reads is at least 14.
// The bench compiles in both builds. Without FIFO_WR_CTRL_AFULL_EN, wafull
// is expected to stay 0.
// ---------------------------------------------------------------------------
module tb_fifo_wr_ctrl;

    localparam int AW = 4;

`ifdef FIFO_WR_CTRL_AFULL_EN
    localparam bit AF_EN = 1'b1;
`else
    localparam bit AF_EN = 1'b0;
`endif

    logic          w_clk;
    logic          w_rst;
    logic          winc;
    logic [AW:0]   r_ptr;
    logic          wfull;
    logic          wafull;
    logic          w_overflow;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [AW:0]   w_ptr;
    logic [AW:0]   w_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [AW:0] m_wbin;
    logic        m_full;
    logic        m_afull;
    logic        m_ovf;
    logic [AW:0] lag_bin;

    fifo_wr_ctrl #(
        .ADDR_WIDTH   (AW),
        .AFULL_THRESH (14)
    ) dut (
        .w_clk      (w_clk),
        .w_rst      (w_rst),
        .winc       (winc),
        .r_ptr      (r_ptr),
        .wfull      (wfull),
        .wafull     (wafull),
        .w_overflow (w_overflow),
        .wen        (wen),
        .waddr      (waddr),
        .w_ptr      (w_ptr),
        .w_count    (w_count)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    // Watchdog: the run is fixed-length, so this fires only on a broken
    // simulator or a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    function automatic logic [AW:0] gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One write-clock cycle.
    // Inputs are driven after the falling edge. The combinational outputs
    // are checked before the rising edge, and the registered outputs are
    // checked 1 time unit after it. 'rp' is the binary read position;
    // r_ptr carries its Gray code.
    task automatic step(input logic w, input logic [AW:0] rp);
        logic        acc;
        logic [AW:0] occ;
        @(negedge w_clk);
        winc  = w;
        r_ptr = gray(rp);
        #1;
        chk("wen",      {31'd0, wen},     {31'd0, w & ~m_full});
        chk("waddr",    {28'd0, waddr},   {28'd0, m_wbin[AW-1:0]});
        chk("w_count",  {27'd0, w_count}, {27'd0, m_wbin - rp});
        @(posedge w_clk);
        acc     = w & ~m_full;
        m_ovf   = m_ovf | (w & m_full);
        m_wbin  = m_wbin + {4'd0, acc};
        occ     = m_wbin - rp;
        m_full  = (occ == 5'd16);
        m_afull = AF_EN && (occ >= 5'd14);
        #1;
        chk("wfull",      {31'd0, wfull},      {31'd0, m_full});
        chk("wafull",     {31'd0, wafull},     {31'd0, m_afull});
        chk("w_overflow", {31'd0, w_overflow}, {31'd0, m_ovf});
        chk("w_ptr",      {27'd0, w_ptr},      {27'd0, gray(m_wbin)});
        $display("t=%0t winc=%0b r_ptr=%b wen_acc=%0b w_ptr=%b wfull=%0b wafull=%0b ovf=%0b cnt=%0d",
                 $time, w, r_ptr, acc, w_ptr, wfull, wafull, w_overflow, w_count);
    endtask

    task automatic model_reset();
        m_wbin  = '0;
        m_full  = 1'b0;
        m_afull = 1'b0;
        m_ovf   = 1'b0;
        lag_bin = '0;
    endtask

    initial begin
        model_reset();
        w_rst = 1'b0;
        winc  = 1'b0;
        r_ptr = '0;

        // ---------------- Reset state ----------------
        #12;
        chk("rst_wfull",   {31'd0, wfull},      32'd0);
        chk("rst_wafull",  {31'd0, wafull},     32'd0);
        chk("rst_ovf",     {31'd0, w_overflow}, 32'd0);
        chk("rst_w_ptr",   {27'd0, w_ptr},      32'd0);
        chk("rst_waddr",   {28'd0, waddr},      32'd0);
        chk("rst_w_count", {27'd0, w_count},    32'd0);
        chk("rst_wen0",    {31'd0, wen},        32'd0);
        winc = 1'b1;
        #1;
        chk("rst_wen1",    {31'd0, wen},        32'd1);
        @(negedge w_clk);
        winc  = 1'b0;
        w_rst = 1'b1;

        // ---------------- Fill to full with r_ptr=0 ----------------
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 5'd0);
            if (i == 12) chk("afull_before_14", {31'd0, wafull}, 32'd0);
            if (i == 13) chk("afull_at_14",     {31'd0, wafull}, {31'd0, AF_EN});
            if (i == 14) chk("full_before_16",  {31'd0, wfull},  32'd0);
        end
        chk("fill_wfull",   {31'd0, wfull},   32'd1);
        chk("fill_w_ptr",   {27'd0, w_ptr},   32'b11000);
        chk("fill_w_count", {27'd0, w_count}, 32'd16);

        // ---------------- Writes while full ----------------
        step(1'b1, 5'd0);
        chk("ovf_set",   {31'd0, w_overflow}, 32'd1);
        chk("ovf_w_ptr", {27'd0, w_ptr},      32'b11000);
        chk("ovf_waddr", {28'd0, waddr},      32'd0);
        step(1'b1, 5'd0);
        step(1'b0, 5'd0);
        chk("ovf_sticky", {31'd0, w_overflow}, 32'd1);

        // ---------------- Read pointer moves off full ----------------
        step(1'b0, 5'd1);
        chk("drain_wfull", {31'd0, wfull},   32'd0);
        chk("drain_count", {27'd0, w_count}, 32'd15);
        step(1'b1, 5'd1);
        chk("refill_wfull", {31'd0, wfull}, 32'd1);
        chk("refill_w_ptr", {27'd0, w_ptr}, 32'b11001);
        // r_ptr advances with winc in the same cycle: the write is dropped.
        step(1'b1, 5'd2);
        chk("same_cycle_drop_w_ptr", {27'd0, w_ptr}, 32'b11001);
        step(1'b1, 5'd2);

        // ---------------- Asynchronous reset mid-burst ----------------
        @(negedge w_clk);
        winc = 1'b1;
        #2;
        w_rst = 1'b0;
        r_ptr = '0;
        #1;
        model_reset();
        chk("arst_wfull",   {31'd0, wfull},      32'd0);
        chk("arst_wafull",  {31'd0, wafull},     32'd0);
        chk("arst_ovf",     {31'd0, w_overflow}, 32'd0);
        chk("arst_w_ptr",   {27'd0, w_ptr},      32'd0);
        chk("arst_waddr",   {28'd0, waddr},      32'd0);
        chk("arst_w_count", {27'd0, w_count},    32'd0);
        @(negedge w_clk);
        winc  = 1'b0;
        w_rst = 1'b1;

        // ---------------- Wrap with a lagging read pointer ----------------
        for (int i = 0; i < 31; i++) begin
            logic [AW:0] rp;
            rp      = lag_bin;
            lag_bin = m_wbin;
            step(1'b1, rp);
            if (i == 0) chk("resume_w_ptr", {27'd0, w_ptr}, 32'b00001);
        end
        chk("wrap_w_ptr31", {27'd0, w_ptr}, 32'b10000);
        chk("wrap_waddr15", {28'd0, waddr}, 32'd15);
        begin
            logic [AW:0] rp;
            rp      = lag_bin;
            lag_bin = m_wbin;
            step(1'b1, rp);
        end
        chk("wrap_w_ptr0",  {27'd0, w_ptr}, 32'b00000);
        chk("wrap_waddr0",  {28'd0, waddr}, 32'd0);
        chk("wrap_nofull",  {31'd0, wfull}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-side pointer and flag controller of the asynchronous FIFO, in the write-clock domain. It accepts write requests, drives the dual-port memory write enable and address, and publishes its pointer in Gray code for synchronization into the read domain. It raises the full, almost-full and overflow indications by comparing against the read pointer, which arrives already synchronized into the write domain.

## Interface
- ADDR_WIDTH, 4: memory address width. Depth is 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AFULL_THRESH, 2^ADDR_WIDTH-2: occupancy at or above which wafull asserts. Legal range is 1..2^ADDR_WIDTH.
- w_clk  in  1  write-domain clock; all state updates on its rising edge.
- w_rst  in  1  asynchronous, active-low reset.
- winc  in  1  write request; data is presented to memory in the same cycle.
- r_ptr  in  ADDR_WIDTH+1  read pointer, Gray-coded, already synchronized to w_clk.
- wfull  out  1  registered full flag.
- wafull  out  1  registered almost-full flag.
- w_overflow  out  1  sticky; a write was attempted while full.
- wen  out  1  memory write enable.
- waddr  out  ADDR_WIDTH  memory write address.
- w_ptr  out  ADDR_WIDTH+1  write pointer, Gray-coded, registered.
- w_count  out  ADDR_WIDTH+1  occupancy as seen by the write side.

## Operation
- A write is accepted when winc=1 and wfull=0.
- Accept condition: wen = winc & ~wfull. wen is combinational.
- Internal binary pointer w_bin:
  - Increments by 1 per accepted write.
  - Wraps modulo 2^(ADDR_WIDTH+1), from all-ones to 0.
- waddr = w_bin[ADDR_WIDTH-1:0].
- Next-state values: w_bin_nxt = w_bin + wen, and w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1), covering all bits.
- w_ptr is registered from w_gray_nxt, in the same cycle as w_bin. There is no extra lag between the binary and Gray pointers.
- Full condition: wfull_nxt = (w_gray_nxt == {~r_ptr[ADDR_WIDTH:ADDR_WIDTH-1], r_ptr[ADDR_WIDTH-2:0]}).
- Occupancy: w_count = w_bin - gray2bin(r_ptr), modulo 2^(ADDR_WIDTH+1). It is combinational.
- Almost-full: wafull_nxt = ((w_bin_nxt - gray2bin(r_ptr)) >= AFULL_THRESH), unsigned.
- w_overflow sets on winc & wfull and clears only on reset.
- Write while full: the request is dropped. wen=0, the pointers hold and w_overflow=1.
- Read pointer advances while full: wfull deasserts on the first edge after r_ptr changes. A winc in that same cycle is still dropped.
- Flags are conservative. r_ptr lags the true read pointer, so wfull can stay high longer than necessary but never deasserts early.

## Timing
- Reset values: wfull=0, wafull=0, w_overflow=0, w_ptr=0, waddr=0, w_count=0 (when r_ptr=0), wen=winc.
- Reset is asynchronous: every register clears immediately on w_rst falling. Release is synchronous to w_clk.
- Reset mid-operation discards the pointer state. The read domain must be reset together with the write domain.
- Write latency: wen and waddr are valid in the same cycle as winc. The pointer and flags update on the following edge.
- Flag latency: wfull and wafull reflect a write on the edge that accepts it. They reflect an r_ptr change on the next edge.
- The block adds no synchronizer stages. The 2-flop synchronizers are external.

## Configuration
- Macro: FIFO_WR_CTRL_AFULL_EN.
- Defined: the threshold compare and wafull register are built as described above.
- Not defined:
  - wafull is tied to 0.
  - The compare and register are removed, and AFULL_THRESH is ignored.
  - The port list is unchanged.

## Structure
- Shared package fifo_pkg holds:
  - bin2gray and gray2bin functions, parameterized by width.
  - The default ADDR_WIDTH constant.
- Sub-module gray2bin converts r_ptr into the binary value used for w_count and wafull. It is the same converter the read side needs for its occupancy.
- Everything else is in one module with four register groups: pointers, wfull, wafull, w_overflow.

## Test plan
Settings: ADDR_WIDTH=4, AFULL_THRESH=14.
- Reset with r_ptr=0 -> wfull=0, wafull=0, w_overflow=0, w_ptr=5'b00000, waddr=0, w_count=0.
- 16 back-to-back writes, r_ptr=0 -> waddr steps 0..15 with wen=1 each cycle. wafull=1 after the 14th edge. wfull=1 after the 16th edge. w_ptr=5'b11000, w_count=16.
- 17th write while full -> wen=0, waddr stays 0, w_ptr stays 5'b11000, w_overflow=1 and remains 1 through later writes.
- Full, then r_ptr=5'b00001 -> next edge wfull=0, w_count=15. One write -> wfull=1 again with w_ptr=5'b11001.
- 31 writes with r_ptr following one cycle behind -> w_ptr reaches gray(31)=5'b10000. The next write wraps to waddr=0 and w_ptr=5'b00000, with no spurious wfull.
- w_rst asserted mid-burst, without waiting for a clock edge -> all registered outputs 0 immediately. After release, writing resumes at waddr=0.
- Build without FIFO_WR_CTRL_AFULL_EN -> wafull stays 0 through the full-fill scenario. All other responses are unchanged.
